// File: rtl/control_unit.sv
// Single-cycle control unit: combinational opcode decode, branch resolution
// against the status flags, and the program counter register.
module control_unit #(
    parameter int OPERAND_WIDTH     = 11,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    input  logic                         status_Z_in,
    input  logic                         status_N_in,
    output logic [OPERAND_WIDTH-1:0]     instruction_address_out,
    output logic [OPERAND_WIDTH-1:0]     operand_out,
    output logic [1:0]                   sel_A_out,
    output logic                         sel_B_out,
    output logic                         alu_op_out,
    output logic                         data_memory_wr_out,
    output logic                         acc_wr_out,
    output logic                         status_wr_out,
    output logic                         acc_reset_out,
    output logic                         status_reset_out
);

    typedef enum logic [4:0] {
        OP_HLT  = 5'd0,
        OP_STO  = 5'd1,
        OP_LD   = 5'd2,
        OP_LDI  = 5'd3,
        OP_ADD  = 5'd4,
        OP_ADDI = 5'd5,
        OP_SUB  = 5'd6,
        OP_SUBI = 5'd7,
        OP_BEQ  = 5'd8,
        OP_BNE  = 5'd9,
        OP_BGT  = 5'd10,
        OP_BGE  = 5'd11,
        OP_BLT  = 5'd12,
        OP_BLE  = 5'd13,
        OP_JMP  = 5'd14
    } opcode_e;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    opcode_e                  opcode;
    logic [OPERAND_WIDTH-1:0] pc_q;
    logic [OPERAND_WIDTH-1:0] pc_d;
    logic                     taken;
    logic                     halt;
    logic                     dmem_wr;
    logic                     acc_wr;
    logic                     status_wr;

    assign opcode      = opcode_e'(instruction_in[INSTRUCTION_WIDTH-1 -: 5]);
    assign operand_out = instruction_in[OPERAND_WIDTH-1:0];

    always_comb begin
        sel_A_out  = SEL_A_MEM;
        sel_B_out  = 1'b0;
        alu_op_out = 1'b0;
        dmem_wr    = 1'b0;
        acc_wr     = 1'b0;
        status_wr  = 1'b0;
        taken      = 1'b0;
        halt       = 1'b0;
        case (opcode)
            OP_HLT:  halt = 1'b1;
            OP_STO:  dmem_wr = 1'b1;
            OP_LD:   acc_wr = 1'b1;
            OP_LDI: begin
                acc_wr    = 1'b1;
                sel_A_out = SEL_A_IMM;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                acc_wr     = 1'b1;
                status_wr  = 1'b1;
                sel_A_out  = SEL_A_ALU;
                sel_B_out  = (opcode == OP_ADDI) || (opcode == OP_SUBI);
                alu_op_out = (opcode == OP_SUB) || (opcode == OP_SUBI);
            end
            OP_BEQ:  taken = status_Z_in;
            OP_BNE:  taken = !status_Z_in;
            OP_BGT:  taken = !status_Z_in && !status_N_in;
            OP_BGE:  taken = !status_N_in;
            OP_BLT:  taken = status_N_in;
            OP_BLE:  taken = status_N_in || status_Z_in;
            OP_JMP:  taken = 1'b1;
            default: ;
        endcase
    end

    // Write enables are gated by reset so nothing downstream commits while held.
    assign data_memory_wr_out = dmem_wr && reset_in;
    assign acc_wr_out         = acc_wr && reset_in;
    assign status_wr_out      = status_wr && reset_in;
    assign acc_reset_out      = !reset_in;
    assign status_reset_out   = !reset_in;

    always_comb begin
        pc_d = pc_q + OPERAND_WIDTH'(1);
        if (taken) begin
            pc_d = operand_out;
        end else if (halt) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign instruction_address_out = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a driver pushes hand-computed expected
// outputs per cycle, a monitor on the falling edge pops and compares them.
module tb_control_unit;

  localparam int OW    = 11;
  localparam int IW    = 16;
  localparam int EXP_W = OW + OW + 9;

  logic          clock_in;
  logic          reset_in;
  logic [IW-1:0] instruction_in;
  logic          status_Z_in;
  logic          status_N_in;
  logic [OW-1:0] instruction_address_out;
  logic [OW-1:0] operand_out;
  logic [1:0]    sel_A_out;
  logic          sel_B_out;
  logic          alu_op_out;
  logic          data_memory_wr_out;
  logic          acc_wr_out;
  logic          status_wr_out;
  logic          acc_reset_out;
  logic          status_reset_out;

  logic [EXP_W-1:0] exp_q[$];
  int               n_compared;
  int               n_failed;
  int               step_no;
  logic             driver_done;

  control_unit #(.OPERAND_WIDTH(OW), .INSTRUCTION_WIDTH(IW)) dut (
    .clock_in               (clock_in),
    .reset_in               (reset_in),
    .instruction_in         (instruction_in),
    .status_Z_in            (status_Z_in),
    .status_N_in            (status_N_in),
    .instruction_address_out(instruction_address_out),
    .operand_out            (operand_out),
    .sel_A_out              (sel_A_out),
    .sel_B_out              (sel_B_out),
    .alu_op_out             (alu_op_out),
    .data_memory_wr_out     (data_memory_wr_out),
    .acc_wr_out             (acc_wr_out),
    .status_wr_out          (status_wr_out),
    .acc_reset_out          (acc_reset_out),
    .status_reset_out       (status_reset_out)
  );

  // clock / reset
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs: exp_pc is the PC value visible during this cycle.
  task automatic step(input logic rst, input logic [IW-1:0] instr,
                      input logic z, input logic n, input logic [OW-1:0] exp_pc,
                      input logic [1:0] e_sel_a, input logic e_sel_b, input logic e_alu,
                      input logic e_dmw, input logic e_accw, input logic e_stw);
    logic [OW-1:0] e_operand;
    @(posedge clock_in);
    #2;
    reset_in       = rst;
    instruction_in = instr;
    status_Z_in    = z;
    status_N_in    = n;
    e_operand      = instr[OW-1:0];
    exp_q.push_back({exp_pc, e_operand, e_sel_a, e_sel_b, e_alu,
                     e_dmw, e_accw, e_stw, !rst, !rst});
  endtask

  // monitor / scoreboard
  initial begin
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] act_v;
    n_compared = 0;
    n_failed   = 0;
    step_no    = 0;
    forever begin
      @(negedge clock_in);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {instruction_address_out, operand_out, sel_A_out, sel_B_out,
                 alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out,
                 acc_reset_out, status_reset_out};
        step_no++;
        n_compared++;
        if (act_v !== exp_v) begin
          n_failed++;
          $display("FAIL step%0d: got pc=%0d opnd=%0d selA=%b selB=%b alu=%b dmw=%b accw=%b stw=%b accr=%b str=%b, expected pc=%0d opnd=%0d selA=%b selB=%b alu=%b dmw=%b accw=%b stw=%b accr=%b str=%b",
                   step_no,
                   act_v[EXP_W-1 -: OW], act_v[EXP_W-OW-1 -: OW], act_v[8:7], act_v[6], act_v[5],
                   act_v[4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[EXP_W-1 -: OW], exp_v[EXP_W-OW-1 -: OW], exp_v[8:7], exp_v[6], exp_v[5],
                   exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // driver: directed program
  initial begin
    driver_done    = 1'b0;
    reset_in       = 1'b0;
    instruction_in = '0;
    status_Z_in    = 1'b0;
    status_N_in    = 1'b0;

    //   rst   instr     Z     N     pc     selA   selB  alu   dmw   accw  stw
    step(1'b0, 16'h080D, 1'b0, 1'b0, 11'd0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // STO in reset
    step(1'b0, 16'h080D, 1'b0, 1'b0, 11'd0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h080D, 1'b0, 1'b0, 11'd0,    2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // STO 13
    step(1'b1, 16'h2002, 1'b0, 1'b0, 11'd1,    2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); // ADD 2
    step(1'b1, 16'h3818, 1'b0, 1'b0, 11'd2,    2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // SUBI 24
    step(1'b1, 16'h1005, 1'b0, 1'b0, 11'd3,    2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // LD 5
    step(1'b1, 16'h1807, 1'b0, 1'b0, 11'd4,    2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // LDI 7
    step(1'b1, 16'h4033, 1'b0, 1'b0, 11'd5,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BEQ 51, Z=0
    step(1'b1, 16'h4033, 1'b1, 1'b0, 11'd6,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BEQ 51, Z=1
    step(1'b1, 16'h5808, 1'b0, 1'b0, 11'd51,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BGE 8, N=0
    step(1'b1, 16'h5808, 1'b0, 1'b1, 11'd8,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BGE 8, N=1
    step(1'b1, 16'h6814, 1'b1, 1'b0, 11'd9,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BLE 20, Z=1
    step(1'b1, 16'h4864, 1'b1, 1'b0, 11'd20,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BNE 100, Z=1
    step(1'b1, 16'h501E, 1'b0, 1'b1, 11'd21,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BGT 30, N=1
    step(1'b1, 16'h6028, 1'b0, 1'b1, 11'd22,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // BLT 40, N=1
    step(1'b1, 16'h0000, 1'b0, 1'b0, 11'd40,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // HLT
    step(1'b1, 16'h0000, 1'b0, 1'b0, 11'd40,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 11'd40,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h77FF, 1'b0, 1'b0, 11'd40,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // JMP 2047
    step(1'b1, 16'h7800, 1'b0, 1'b0, 11'd2047, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // NOP at top
    step(1'b1, 16'hF8FF, 1'b0, 1'b0, 11'd0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // NOP after wrap
    step(1'b0, 16'h71F4, 1'b0, 1'b0, 11'd1,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // JMP 500 under reset
    step(1'b0, 16'h080D, 1'b0, 1'b0, 11'd0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // STO masked by reset
    step(1'b1, 16'h2807, 1'b0, 1'b0, 11'd0,    2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); // ADDI 7
    step(1'b1, 16'h3003, 1'b0, 1'b0, 11'd1,    2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); // SUB 3
    driver_done = 1'b1;
  end

  // final report
  initial begin
    int budget;
    wait (driver_done === 1'b1);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clock_in);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_compared++;
      n_failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clock_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: OPERAND_WIDTH, default 11, operand and instruction-address width; INSTRUCTION_WIDTH, default 16, instruction word width (opcode = upper 5 bits).
REQ-002 clock_in  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_in  input  1  synchronous, active-low reset.
REQ-004 instruction_in  input  INSTRUCTION_WIDTH  current instruction: opcode [15:11], operand [10:0].
REQ-005 status_Z_in  input  1  accumulator-zero flag from status register.
REQ-006 status_N_in  input  1  accumulator-negative flag from status register.
REQ-007 instruction_address_out  output  OPERAND_WIDTH  program counter (PC), addresses instruction memory.
REQ-008 operand_out  output  OPERAND_WIDTH  operand field; data address or immediate.
REQ-009 sel_A_out  output  2  accumulator source: 00 data memory, 01 immediate (operand), 10 ALU result, 11 unused.
REQ-010 sel_B_out  output  1  ALU B source: 0 data memory, 1 immediate.
REQ-011 alu_op_out  output  1  0 add, 1 subtract.
REQ-012 data_memory_wr_out, acc_wr_out, status_wr_out  output  1 each  write enables for data memory, accumulator, status register.
REQ-013 acc_reset_out, status_reset_out  output  1 each  clear requests for accumulator and status register.

Function
REQ-014 operand_out SHALL equal instruction_in[10:0] combinationally, at all times.
REQ-015 The opcode decode SHALL be as follows:
- 00000 HLT
- 00001 STO
- 00010 LD
- 00011 LDI
- 00100 ADD
- 00101 ADDI
- 00110 SUB
- 00111 SUBI
- 01000 BEQ
- 01001 BNE
- 01010 BGT
- 01011 BGE
- 01100 BLT
- 01101 BLE
- 01110 JMP
- 01111-11111: NOP.
REQ-016 Decode SHALL be combinational (single-cycle); defaults for every opcode: sel_A=00, sel_B=0, alu_op=0, all write enables 0.
REQ-017 Overrides from the defaults, per opcode:
- STO: data_memory_wr=1
- LD: acc_wr=1, sel_A=00
- LDI: acc_wr=1, sel_A=01
REQ-018 Arithmetic overrides: ADD/ADDI/SUB/SUBI SHALL drive acc_wr=1, status_wr=1, sel_A=10; sel_B=1 for ADDI/SUBI; alu_op=1 for SUB/SUBI.
REQ-019 Branches, JMP, HLT and NOP SHALL assert no write enable.
REQ-020 Branch taken conditions:
- BEQ: Z=1
- BNE: Z=0
- BGT: Z=0 and N=0
- BGE: N=0
- BLT: N=1
- BLE: N=1 or Z=1
- JMP: always.
REQ-021 Next PC: taken branch/JMP -> operand; HLT -> PC unchanged; otherwise PC+1, modulo 2^OPERAND_WIDTH (2047 wraps to 0).
REQ-022 PC SHALL update on every rising clock edge with reset_in=1; status flags are sampled combinationally in the cycle of the branch.

Reset
REQ-023 On a rising edge with reset_in=0, PC SHALL load 0.
REQ-024 While reset_in=0, acc_reset_out and status_reset_out SHALL be 1; both SHALL be 0 while reset_in=1.
REQ-025 While reset_in=0, data_memory_wr_out, acc_wr_out and status_wr_out SHALL be forced to 0.
REQ-026 A reset asserted mid-program SHALL override any pending branch or increment at that edge.
REQ-027 First instruction after reset release SHALL be fetched from address 0.

Verification
REQ-028 Reset and STO: reset_in=0 for 2 edges, then 1 with instruction 0x080D (STO 13) -> while in reset: PC=0, acc_reset/status_reset=1, data_memory_wr=0; after release: data_memory_wr=1, operand_out=13, PC increments 0->1->2.
REQ-029 ADD 0x2002 -> acc_wr=1, status_wr=1, sel_A=10, sel_B=0, alu_op=0, operand_out=2; SUBI 0x3818 -> alu_op=1, sel_B=1, operand_out=24.
REQ-030 BEQ 0x4033 with Z=0 -> PC+1; with Z=1 -> PC=51 on next edge; no write enables asserted in either case.
REQ-031 BGE 0x5808 with N=0 -> PC=8; with N=1 -> PC+1; BLE with N=0, Z=1 -> taken.
REQ-032 HLT 0x0000 -> PC holds across 3 edges; JMP to 2047 followed by a NOP -> PC goes 2047 then 0 (wrap).
REQ-033 Reset asserted during a taken JMP -> PC=0 at that edge, not the jump target.
